// File: rtl/mc_control.sv
// Multi-cycle MIPS main controller: Moore FSM driving datapath enables and mux selects,
// with a retired-instruction counter and a sticky illegal-instruction flag.
module mc_control #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_ctrl,
   output logic             ext_op,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StExeR   = 4'd2,
      StExeI   = 4'd3,
      StMemAdr = 4'd4,
      StMemRd  = 4'd5,
      StMemWr  = 4'd6,
      StWbMem  = 4'd7,
      StWbAlu  = 4'd8,
      StBranch = 4'd9,
      StJal    = 4'd10,
      StJr     = 4'd11,
      StHalt   = 4'd12
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] FnAddu  = 6'b100001;
   localparam logic [5:0] FnSubu  = 6'b100011;
   localparam logic [5:0] FnJr    = 6'b001000;
   localparam logic [5:0] FnNop   = 6'b000000;

   state_e           r_state;
   state_e           w_next;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StFetch;
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == StHalt) r_illegal <= 1'b1;
         if (w_retire) r_retired <= r_retired + 1'b1;
      end
   end

   // A transition back to FETCH retires an instruction, except the FETCH self-path and HALT.
   assign w_retire = (w_next == StFetch) && (r_state != StFetch) && (r_state != StHalt);

   always_comb begin
      w_next = StFetch;
      unique case (r_state)
         StFetch:  w_next = StDecode;
         StDecode: begin
            w_next = StHalt;
            if (op == OpRtype) begin
               if (funct == FnAddu || funct == FnSubu) w_next = StExeR;
               else if (funct == FnJr)                 w_next = StJr;
               else if (funct == FnNop)                w_next = StFetch;
            end else if (op == OpOri || op == OpLui) begin
               w_next = StExeI;
            end else if (op == OpLw || op == OpSw) begin
               w_next = StMemAdr;
            end else if (op == OpBeq) begin
               w_next = StBranch;
            end else if (op == OpJal) begin
               w_next = StJal;
            end
         end
         StExeR:   w_next = StWbAlu;
         StExeI:   w_next = StWbAlu;
         StMemAdr: w_next = (op == OpSw) ? StMemWr : StMemRd;
         StMemRd:  w_next = StWbMem;
         StHalt:   w_next = StHalt;
         default:  w_next = StFetch;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 2'b00;
      ext_op     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      unique case (r_state)
         StFetch: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
         end
         StDecode: begin
            alu_src_b = 2'b11;
            ext_op    = 1'b1;
         end
         StExeR: begin
            alu_src_a = 1'b1;
            alu_ctrl  = (funct == FnSubu) ? 2'b01 : 2'b00;
         end
         StExeI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = (op == OpLui) ? 2'b11 : 2'b10;
         end
         StWbAlu: begin
            reg_write = 1'b1;
            reg_dst   = (op == OpRtype) ? 2'b01 : 2'b00;
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
         end
         StMemRd: mem_read = 1'b1;
         StWbMem: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
         end
         StMemWr: mem_write = 1'b1;
         StBranch: begin
            alu_src_a = 1'b1;
            alu_ctrl  = 2'b01;
            pc_src    = 2'b01;
            pc_write  = zero;
         end
         StJal: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            pc_src     = 2'b10;
            pc_write   = 1'b1;
         end
         StJr: begin
            pc_src   = 2'b11;
            pc_write = 1'b1;
         end
         default: ;
      endcase
      // Reset is asynchronous, so suppress writes before the state register settles.
      if (!reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         mem_read  = 1'b0;
      end
   end

   assign state   = r_state;
   assign illegal = r_illegal;
   assign retired = r_retired;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class through its state sequence
// and checks the packed control vector, state code, counter and illegal flag.
module tb_mc_control;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    op;
   logic [5:0]    funct;
   logic          zero;
   logic          pc_write, ir_write, mem_read, mem_write, alu_src_a, ext_op, reg_write;
   logic [1:0]    pc_src, alu_src_b, alu_ctrl, reg_dst, mem_to_reg;
   logic [3:0]    state;
   logic          illegal;
   logic [CW-1:0] retired;
   logic [16:0]   w_ctrl;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mc_control #(.CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .ext_op     (ext_op),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .state      (state),
      .illegal    (illegal),
      .retired    (retired)
   );

   // Fields: pw, pc_src, ir, mrd, mwr, src_a, src_b, alu, ext, rw, reg_dst, mem_to_reg
   assign w_ctrl = {pc_write, pc_src, ir_write, mem_read, mem_write, alu_src_a, alu_src_b,
                    alu_ctrl, ext_op, reg_write, reg_dst, mem_to_reg};

   localparam logic [16:0] C_RST    = 17'b0_00_0_0_0_0_01_00_0_0_00_00;
   localparam logic [16:0] C_FETCH  = 17'b1_00_1_0_0_0_01_00_0_0_00_00;
   localparam logic [16:0] C_DECODE = 17'b0_00_0_0_0_0_11_00_1_0_00_00;
   localparam logic [16:0] C_ADDU   = 17'b0_00_0_0_0_1_00_00_0_0_00_00;
   localparam logic [16:0] C_SUBU   = 17'b0_00_0_0_0_1_00_01_0_0_00_00;
   localparam logic [16:0] C_ORI    = 17'b0_00_0_0_0_1_10_10_0_0_00_00;
   localparam logic [16:0] C_LUI    = 17'b0_00_0_0_0_1_10_11_0_0_00_00;
   localparam logic [16:0] C_WB_R   = 17'b0_00_0_0_0_0_00_00_0_1_01_00;
   localparam logic [16:0] C_WB_I   = 17'b0_00_0_0_0_0_00_00_0_1_00_00;
   localparam logic [16:0] C_MEMADR = 17'b0_00_0_0_0_1_10_00_1_0_00_00;
   localparam logic [16:0] C_MEMRD  = 17'b0_00_0_1_0_0_00_00_0_0_00_00;
   localparam logic [16:0] C_WB_MEM = 17'b0_00_0_0_0_0_00_00_0_1_00_01;
   localparam logic [16:0] C_MEMWR  = 17'b0_00_0_0_1_0_00_00_0_0_00_00;
   localparam logic [16:0] C_BR_T   = 17'b1_01_0_0_0_1_00_01_0_0_00_00;
   localparam logic [16:0] C_BR_NT  = 17'b0_01_0_0_0_1_00_01_0_0_00_00;
   localparam logic [16:0] C_JAL    = 17'b1_10_0_0_0_0_00_00_0_1_10_10;
   localparam logic [16:0] C_JR     = 17'b1_11_0_0_0_0_00_00_0_0_00_00;
   localparam logic [16:0] C_HALT   = 17'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check state and controls in the current cycle, then advance one clock.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] ctrl);
      #1;
      chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
      chk({tag, ".ctrl"}, {15'd0, w_ctrl}, {15'd0, ctrl});
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      op    = 6'b0;
      funct = 6'b0;
      zero  = 1'b0;
      #3;
      chk("rst.state", {28'd0, state}, 32'd0);
      chk("rst.ctrl", {15'd0, w_ctrl}, {15'd0, C_RST});
      chk("rst.retired", {28'd0, retired}, 32'd0);
      chk("rst.illegal", {31'd0, illegal}, 32'd0);
      repeat (2) @(negedge clk);
      chk("rst_hold.ctrl", {15'd0, w_ctrl}, {15'd0, C_RST});
      reset = 1'b1;

      // addu: 4 cycles
      op = 6'b000000; funct = 6'b100001;
      cyc("addu0", 4'd0, C_FETCH);
      cyc("addu1", 4'd1, C_DECODE);
      cyc("addu2", 4'd2, C_ADDU);
      cyc("addu3", 4'd8, C_WB_R);
      #1 chk("addu.retired", {28'd0, retired}, 32'd1);

      // lw: 5 cycles
      op = 6'b100011; funct = 6'b000000;
      cyc("lw0", 4'd0, C_FETCH);
      cyc("lw1", 4'd1, C_DECODE);
      cyc("lw2", 4'd4, C_MEMADR);
      cyc("lw3", 4'd5, C_MEMRD);
      cyc("lw4", 4'd7, C_WB_MEM);
      #1 chk("lw.retired", {28'd0, retired}, 32'd2);

      // beq taken then not taken
      op = 6'b000100; zero = 1'b1;
      cyc("beqt0", 4'd0, C_FETCH);
      cyc("beqt1", 4'd1, C_DECODE);
      cyc("beqt2", 4'd9, C_BR_T);
      zero = 1'b0;
      cyc("beqn0", 4'd0, C_FETCH);
      cyc("beqn1", 4'd1, C_DECODE);
      cyc("beqn2", 4'd9, C_BR_NT);
      #1 chk("beq.retired", {28'd0, retired}, 32'd4);

      // jal then jr
      op = 6'b000011;
      cyc("jal0", 4'd0, C_FETCH);
      cyc("jal1", 4'd1, C_DECODE);
      cyc("jal2", 4'd10, C_JAL);
      op = 6'b000000; funct = 6'b001000;
      cyc("jr0", 4'd0, C_FETCH);
      cyc("jr1", 4'd1, C_DECODE);
      cyc("jr2", 4'd11, C_JR);
      #1 chk("jr.retired", {28'd0, retired}, 32'd6);

      // subu, ori, lui
      funct = 6'b100011;
      cyc("subu0", 4'd0, C_FETCH);
      cyc("subu1", 4'd1, C_DECODE);
      cyc("subu2", 4'd2, C_SUBU);
      cyc("subu3", 4'd8, C_WB_R);
      op = 6'b001101; funct = 6'b000000;
      cyc("ori0", 4'd0, C_FETCH);
      cyc("ori1", 4'd1, C_DECODE);
      cyc("ori2", 4'd3, C_ORI);
      cyc("ori3", 4'd8, C_WB_I);
      op = 6'b001111;
      cyc("lui0", 4'd0, C_FETCH);
      cyc("lui1", 4'd1, C_DECODE);
      cyc("lui2", 4'd3, C_LUI);
      cyc("lui3", 4'd8, C_WB_I);
      #1 chk("lui.retired", {28'd0, retired}, 32'd9);

      // sw aborted by reset while in MEMWR
      op = 6'b101011;
      cyc("sw0", 4'd0, C_FETCH);
      cyc("sw1", 4'd1, C_DECODE);
      cyc("sw2", 4'd4, C_MEMADR);
      #1;
      chk("sw3.state", {28'd0, state}, 32'd6);
      chk("sw3.ctrl", {15'd0, w_ctrl}, {15'd0, C_MEMWR});
      reset = 1'b0;
      #1;
      chk("abort.mem_write", {31'd0, mem_write}, 32'd0);
      chk("abort.state", {28'd0, state}, 32'd0);
      chk("abort.retired", {28'd0, retired}, 32'd0);
      chk("abort.ctrl", {15'd0, w_ctrl}, {15'd0, C_RST});
      @(negedge clk);
      reset = 1'b1;

      // 16 nops wrap the 4-bit counter
      op = 6'b000000; funct = 6'b000000;
      for (int i = 0; i < 16; i++) begin
         cyc("nop0", 4'd0, C_FETCH);
         cyc("nop1", 4'd1, C_DECODE);
         if (i == 14) begin
            #1 chk("nop.retired15", {28'd0, retired}, 32'd15);
         end
      end
      #1 chk("nop.wrap", {28'd0, retired}, 32'd0);

      // undefined op halts and latches illegal
      op = 6'b111111;
      cyc("ill0", 4'd0, C_FETCH);
      #1 chk("ill.pre_illegal", {31'd0, illegal}, 32'd0);
      cyc("ill1", 4'd1, C_DECODE);
      #1 chk("ill.illegal", {31'd0, illegal}, 32'd1);
      op = 6'b000000;
      for (int i = 0; i < 20; i++) cyc("halt", 4'd12, C_HALT);
      #1;
      chk("halt.retired", {28'd0, retired}, 32'd0);
      chk("halt.illegal", {31'd0, illegal}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main controller for the MIPS core. A Moore FSM sequences the shared datapath (PC, IR, register file, ALU, extender, data memory) across several cycles per instruction. It drives every write enable and mux select. It also keeps a retired-instruction counter and a sticky illegal-instruction flag. It sits beside the datapath in the core top and decodes the latched IR fields.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; forces state to FETCH, clears counter and illegal flag
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 {PC[31:28],IR[25:0],00}, 11 register rs
- ir_write  out  1  IR load from instruction memory
- mem_read  out  1  DM read strobe
- mem_write  out  1  DM write enable
- alu_src_a  out  1  0 PC, 1 A register
- alu_src_b  out  2  00 B register, 01 constant 4, 10 ext imm, 11 ext imm<<2
- alu_ctrl  out  2  00 add, 01 sub, 10 or, 11 lui (B<<16)
- ext_op  out  1  0 zero-extend, 1 sign-extend
- reg_write  out  1  GRF write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- state  out  4  current state code
- illegal  out  1  sticky illegal-instruction flag
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- States: FETCH=0, DECODE=1, EXE_R=2, EXE_I=3, MEMADR=4, MEMRD=5, MEMWR=6, WB_MEM=7, WB_ALU=8, BRANCH=9, JAL=10, JR=11, HALT=12. Codes 13-15 go to FETCH on the next clock.
- Outputs are combinational from the state, plus op/funct where stated. Any output not listed for a state is 0.
- FETCH: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, add, pc_src=00. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, add (precomputes the branch target into ALUOut). Next state by op/funct:
  - op 000000 with funct 100001 (addu) or 100011 (subu): EXE_R.
  - op 000000, funct 001000 (jr): JR.
  - op 000000, funct 000000 (nop): FETCH; counts as retired.
  - op 001101 (ori) or 001111 (lui): EXE_I.
  - op 100011 (lw) or 101011 (sw): MEMADR.
  - op 000100 (beq): BRANCH.
  - op 000011 (jal): JAL.
  - Anything else: HALT, and illegal is set.
- EXE_R: alu_src_a=1, alu_src_b=00, alu_ctrl add for addu, sub for subu. Next state WB_ALU.
- EXE_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_ctrl or for ori, lui for lui. Next state WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=00, reg_dst=01 if op==0, else 00. Next state FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1. Next state WB_MEM.
- WB_MEM: reg_write=1, reg_dst=00, mem_to_reg=01. Next state FETCH.
- MEMWR: mem_write=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_write=zero. Next state FETCH.
- JAL: reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4), pc_src=10, pc_write=1. Next state FETCH.
- JR: pc_src=11, pc_write=1. Next state FETCH.
- HALT: all enables 0; stays in HALT until reset.
- retired increments on every clock edge that moves into FETCH from a state other than FETCH or HALT. It wraps to 0 after all-ones.

## Timing
- While reset is low:
  - state=FETCH, retired=0, illegal=0.
  - pc_write, ir_write, reg_write, mem_write and mem_read are forced to 0 combinationally.
  - All other outputs take their FETCH values.
- The first fetch happens on the first rising clk edge after reset goes high.
- Cycles per instruction:
  - nop: 2.
  - beq, jal, jr: 3.
  - addu, subu, ori, lui, sw: 4.
  - lw: 5.
- Reset asserted mid-instruction aborts it immediately. No write enable is asserted after reset falls, and the aborted instruction is not counted.
- illegal rises on the clock edge that enters HALT and holds until reset.

## Test plan
- Reset low, then high; IR=addu $3,$1,$2 with $1=5, $2=7 -> states 0,1,2,8,0; reg_write high only in state 8 with reg_dst=01; $3=12; retired=1.
- lw $4,8($0) with DM[8]=0xDEADBEEF -> states 0,1,4,5,7,0; mem_read high only in state 5; $4=0xDEADBEEF after 5 cycles.
- beq with zero=1, then beq with zero=0 -> pc_write high in BRANCH for the first only; both take 3 cycles.
- jal at PC=0x3000 targeting 0x3010, then jr $31 -> $31=0x3004, PC=0x3010, then PC=0x3004; retired=2.
- Reset pulled low while in MEMWR of a sw -> mem_write drops to 0 in the same cycle; state=0 and retired=0.
- Undefined op 111111 -> HALT, illegal=1; 20 more clocks show no enables and retired unchanged. With CNT_W=4 and 16 nops, retired wraps to 0.
